// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Input sequencer for an N-row systolic array. It accepts one N-lane column
//   vector of matrix A per handshake and emits it with lane i delayed by i
//   steps. The skew triangle is zero-filled. Each job runs len feed steps and
//   then N-1 drain steps, and done pulses together with the final beat.
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low; clears all state and outputs
//   start     in   job start pulse, sampled in IDLE only
//   len       in   vectors per job (clamped to MAX_LEN, 0 ignored)
//   in_valid  in   in_data valid
//   in_ready  out  feeder accepts in_data (FEED state)
//   in_data   in   lane i = [i*DATA_W +: DATA_W]
//   out_valid out  out_data is a new beat
//   out_data  out  skewed lanes, same packing as in_data
//   busy      out  job in progress, through the final beat
//   done      out  one-cycle pulse with the final beat
module systolic_skew_feeder #(
  parameter  int N       = 2,
  parameter  int DATA_W  = 16,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  output logic [N*DATA_W-1:0] out_data,
  output logic                busy,
  output logic                done
);

  localparam int DC_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

  state_t           r_state, w_state_nx;
  logic [LEN_W-1:0] r_len, r_cnt, w_len_clamp;
  logic [DC_W-1:0]  r_dcnt;
  logic             r_ovalid, r_busy, r_done;
  logic             w_start_acc, w_accept, w_step;
  logic             w_last_acc, w_last_drain, w_final;

  always_comb begin
    w_len_clamp  = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    w_start_acc  = (r_state == S_IDLE) && start && (len != '0);
    w_accept     = (r_state == S_FEED) && in_valid;
    w_step       = w_accept || (r_state == S_DRAIN);
    w_last_acc   = w_accept && ((r_cnt + LEN_W'(1)) == r_len);
    w_last_drain = (r_state == S_DRAIN) && (r_dcnt == DC_W'(N - 2));
    // With a single lane there is no skew, so the last accept ends the job.
    w_final      = (N == 1) ? w_last_acc : w_last_drain;

    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start_acc) w_state_nx = S_FEED;
      S_FEED:  if (w_last_acc)  w_state_nx = (N == 1) ? S_IDLE : S_DRAIN;
      S_DRAIN: if (w_last_drain) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_ovalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_ovalid <= w_step;
      r_done   <= w_final;
      // Busy covers the cycle carrying the final beat, then drops.
      r_busy   <= (w_state_nx != S_IDLE) || w_final;
      if (w_start_acc) begin
        r_len  <= w_len_clamp;
        r_cnt  <= '0;
        r_dcnt <= '0;
      end else begin
        if (w_accept && (r_cnt != r_len))
          r_cnt <= r_cnt + LEN_W'(1);
        if ((r_state == S_DRAIN) && !w_last_drain)
          r_dcnt <= r_dcnt + DC_W'(1);
      end
    end
  end

  always_comb begin
    in_ready  = (r_state == S_FEED);
    out_valid = r_ovalid;
    busy      = r_busy;
    done      = r_done;
  end

  // Lane g: (g+1)-stage shift register packed into one vector, stage 0 in
  // the low bits; the top stage is the lane output.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [(g+1)*DATA_W-1:0] r_sr;
    logic [(g+1)*DATA_W-1:0] w_shift;
    logic [DATA_W-1:0]       w_din;

    always_comb w_din = (r_state == S_FEED) ? in_data[g*DATA_W +: DATA_W] : '0;

    if (g == 0) begin : g_first
      always_comb w_shift = w_din;
    end else begin : g_rest
      always_comb w_shift = {r_sr[g*DATA_W-1:0], w_din};
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)           r_sr <= '0;
      else if (w_start_acc) r_sr <= '0;
      else if (w_step)      r_sr <= w_shift;
    end

    assign out_data[g*DATA_W +: DATA_W] = r_sr[g*DATA_W +: DATA_W];
  end

endmodule
